data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache sitting between the 8-bit single-cycle CPU's load/store path and the 32-bit-block data memory. It serves CPU byte reads and writes and stalls the CPU through BUSYWAIT on a miss. On a miss it writes back a dirty victim block, then fetches the requested block, using a request/busywait handshake with memory.

---
 rtl/data_cache_if.sv | 25 ++
 rtl/data_cache.sv | 94 +++++++++
 tb/tb_data_cache.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - CPU load/store port and memory block port of the data cache
interface data_cache_if;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate 8x4-byte data cache
module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    data_cache_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_data [0:7];
    logic [2:0]  r_tag  [0:7];
    logic [7:0]  r_valid;
    logic [7:0]  r_dirty;

    logic [2:0]  w_tag;
    logic [2:0]  w_index;
    logic [1:0]  w_offset;
    logic [4:0]  w_bit;
    logic [31:0] w_block;
    logic        w_req;
    logic        w_hit;
    logic        w_fill;
    logic        w_wr_hit;

    assign w_tag    = bus.ADDRESS[7:5];
    assign w_index  = bus.ADDRESS[4:2];
    assign w_offset = bus.ADDRESS[1:0];
    assign w_bit    = {w_offset, 3'b000};
    assign w_block  = r_data[w_index];
    assign w_req    = bus.READ | bus.WRITE;
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);

    always_comb begin
        w_next            = r_state;
        w_fill            = 1'b0;
        w_wr_hit          = 1'b0;
        bus.READDATA      = 8'h00;
        bus.BUSYWAIT      = 1'b0;
        bus.MEM_READ      = 1'b0;
        bus.MEM_WRITE     = 1'b0;
        bus.MEM_ADDRESS   = 6'h00;
        bus.MEM_WRITEDATA = 32'h0;
        case (r_state)
            S_IDLE: begin
                bus.BUSYWAIT = w_req && !w_hit;
                if (bus.READ && w_hit)
                    bus.READDATA = w_block[w_bit +: 8];
                // a simultaneous READ and WRITE is handled as a store
                w_wr_hit = bus.WRITE && w_hit;
                if (w_req && !w_hit)
                    w_next = (r_valid[w_index] && r_dirty[w_index]) ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: begin
                bus.BUSYWAIT      = 1'b1;
                bus.MEM_WRITE     = 1'b1;
                bus.MEM_ADDRESS   = {r_tag[w_index], w_index};
                bus.MEM_WRITEDATA = w_block;
                if (!bus.MEM_BUSYWAIT)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                bus.BUSYWAIT    = 1'b1;
                bus.MEM_READ    = 1'b1;
                bus.MEM_ADDRESS = bus.ADDRESS[7:2];
                if (!bus.MEM_BUSYWAIT) begin
                    w_fill = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Reset leaves data and tags untouched; clearing valid/dirty is enough.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_valid <= 8'h00;
            r_dirty <= 8'h00;
        end else begin
            r_state <= w_next;
            if (w_fill) begin
                r_data[w_index]  <= bus.MEM_READDATA;
                r_tag[w_index]   <= w_tag;
                r_valid[w_index] <= 1'b1;
                r_dirty[w_index] <= 1'b0;
            end else if (w_wr_hit) begin
                r_data[w_index][w_bit +: 8] <= bus.WRITEDATA;
                r_dirty[w_index]            <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache
module tb_data_cache;
    logic CLK = 1'b0;
    logic RESET;
    data_cache_if bus ();

    data_cache dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_blk [0:63];
    int          mem_lat = 0;
    int          cnt = 0;
    logic [1:0]  kind;
    logic [1:0]  prev_kind = 2'b00;
    logic        both_seen = 1'b0;
    int          wb_count = 0;
    logic [5:0]  last_wb_addr = 6'h00;
    logic [31:0] last_wb_data = 32'h0;

    assign bus.MEM_READDATA = mem_blk[bus.MEM_ADDRESS];

    // Memory: each request completes after mem_lat extra cycles.
    always @(negedge CLK) begin
        kind = {bus.MEM_READ, bus.MEM_WRITE};
        if (kind != prev_kind) cnt = 0;
        prev_kind = kind;
        if (kind == 2'b11) both_seen = 1'b1;
        if (kind != 2'b00) begin
            if (cnt >= mem_lat) begin
                bus.MEM_BUSYWAIT = 1'b0;
                if (bus.MEM_WRITE) begin
                    mem_blk[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
                    wb_count++;
                    last_wb_addr = bus.MEM_ADDRESS;
                    last_wb_data = bus.MEM_WRITEDATA;
                end
            end else begin
                bus.MEM_BUSYWAIT = 1'b1;
            end
            cnt++;
        end else begin
            bus.MEM_BUSYWAIT = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic cpu(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
        @(negedge CLK);
        bus.READ      = rd;
        bus.WRITE     = wr;
        bus.ADDRESS   = addr;
        bus.WRITEDATA = wd;
        #1;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (bus.BUSYWAIT && n < max) begin
            step();
            n++;
        end
        if (bus.BUSYWAIT) check("busywait_timeout", 1, 0);
    endtask

    int n;
    int wb0;
    logic flag;

    initial begin
        for (int i = 0; i < 64; i++) mem_blk[i] = 32'h0;
        mem_blk[6'h01] = 32'hDDCCBBAA;
        mem_blk[6'h09] = 32'h44332211;
        mem_blk[6'h38] = 32'h0C0B0A09;
        mem_blk[6'h00] = 32'h87654321;
        bus.MEM_BUSYWAIT = 1'b1;
        RESET = 1'b1;
        bus.READ = 1'b0; bus.WRITE = 1'b0; bus.ADDRESS = 8'h00; bus.WRITEDATA = 8'h00;
        step(); step();
        check("rst_busywait", bus.BUSYWAIT, 0);
        check("rst_mem_read", bus.MEM_READ, 0);
        check("rst_mem_write", bus.MEM_WRITE, 0);
        check("rst_readdata", bus.READDATA, 8'h00);
        @(negedge CLK);
        RESET = 1'b0;

        // clean miss, latency 5
        mem_lat = 5;
        cpu(1, 0, 8'h05, 8'h00);
        check("miss1_busy", bus.BUSYWAIT, 1);
        check("miss1_memread_early", bus.MEM_READ, 0);
        step();
        check("miss1_memread", bus.MEM_READ, 1);
        check("miss1_memaddr", bus.MEM_ADDRESS, 6'h01);
        check("miss1_memwrite", bus.MEM_WRITE, 0);
        wait_done(50, n);
        check("miss1_cycles", n, 6);
        check("miss1_readdata", bus.READDATA, 8'hBB);
        check("miss1_memread_off", bus.MEM_READ, 0);

        // write hit then read hit
        cpu(0, 1, 8'h06, 8'h5A);
        check("wrhit_busy", bus.BUSYWAIT, 0);
        cpu(1, 0, 8'h06, 8'h00);
        check("rdhit_busy", bus.BUSYWAIT, 0);
        check("rdhit_data", bus.READDATA, 8'h5A);

        // dirty miss: write back block 1, then fetch 0x09
        mem_lat = 2;
        cpu(1, 0, 8'h25, 8'h00);
        check("dmiss_busy", bus.BUSYWAIT, 1);
        step();
        check("wb_memwrite", bus.MEM_WRITE, 1);
        check("wb_memread", bus.MEM_READ, 0);
        check("wb_addr", bus.MEM_ADDRESS, 6'h01);
        check("wb_data", bus.MEM_WRITEDATA, 32'hDD5ABBAA);
        n = 0;
        while (!bus.MEM_READ && n < 20) begin
            step();
            n++;
        end
        check("dmiss_fetch_seen", bus.MEM_READ, 1);
        check("dmiss_fetch_addr", bus.MEM_ADDRESS, 6'h09);
        check("dmiss_fetch_nowrite", bus.MEM_WRITE, 0);
        wait_done(50, n);
        check("dmiss_readdata", bus.READDATA, 8'h22);
        check("dmiss_wb_addr", last_wb_addr, 6'h01);
        check("dmiss_wb_data", last_wb_data, 32'hDD5ABBAA);

        // write miss on invalid block, zero-latency memory
        mem_lat = 0;
        wb0 = wb_count;
        cpu(0, 1, 8'hE3, 8'h77);
        check("wmiss_busy", bus.BUSYWAIT, 1);
        wait_done(50, n);
        check("wmiss_cycles", n, 2);
        check("wmiss_no_wb", wb_count, wb0);
        cpu(1, 0, 8'hE3, 8'h00);
        check("wmiss_rd_busy", bus.BUSYWAIT, 0);
        check("wmiss_rd_data", bus.READDATA, 8'h77);
        cpu(1, 0, 8'h03, 8'h00);
        wait_done(50, n);
        check("evict_cycles", n, 3);
        check("evict_wb_count", wb_count, wb0 + 1);
        check("evict_wb_addr", last_wb_addr, 6'h38);
        check("evict_wb_data", last_wb_data, 32'h770B0A09);
        check("evict_readdata", bus.READDATA, 8'h87);

        // reset during fetch
        mem_lat = 10;
        cpu(1, 0, 8'h05, 8'h00);
        step();
        check("abort_memread_on", bus.MEM_READ, 1);
        @(negedge CLK);
        RESET = 1'b1;
        step();
        check("abort_memread_off", bus.MEM_READ, 0);
        check("abort_miss_again", bus.BUSYWAIT, 1);
        RESET = 1'b0;
        mem_lat = 1;
        wait_done(50, n);
        check("abort_refetch_cycles", n, 3);
        check("abort_refetch_data", bus.READDATA, 8'hBB);

        // idle with no request
        cpu(0, 0, 8'h05, 8'h00);
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            flag = flag | bus.BUSYWAIT | bus.MEM_READ | bus.MEM_WRITE | (bus.READDATA != 8'h00);
            step();
        end
        check("idle_quiet", flag, 0);
        check("never_both_mem_req", both_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
